// File: rtl/be_dispatch_queue_if.sv
// Decoded-instruction stream, issue handshake and branch-recovery signals
// between the front end, the dispatch queue and execute/issue.
interface be_dispatch_queue_if #(
    parameter int ELS_P      = 4,
    parameter int WIDTH_P    = 32,
    parameter int PC_WIDTH_P = 32
);
    localparam int CNT_W = $clog2(ELS_P) + 1;

    // Front-end instruction stream
    logic                  v_i;
    logic [WIDTH_P-1:0]    data_i;
    logic                  ready_o;

    // Issue side
    logic                  deq_v_o;
    logic [WIDTH_P-1:0]    deq_data_o;
    logic                  deq_yumi_i;

    // Branch resolution from execute
    logic                  br_v_i;
    logic [PC_WIDTH_P-1:0] br_predicted_pc_i;
    logic [PC_WIDTH_P-1:0] br_actual_pc_i;

    // Recovery toward the front end and status
    logic                  mis_predict_o;
    logic [PC_WIDTH_P-1:0] branch_mis_target_o;
    logic [CNT_W-1:0]      count_o;
    logic [15:0]           mispredict_cnt_o;

    // Queue side
    modport slave (
        input  v_i, data_i, deq_yumi_i, br_v_i, br_predicted_pc_i, br_actual_pc_i,
        output ready_o, deq_v_o, deq_data_o, mis_predict_o, branch_mis_target_o,
               count_o, mispredict_cnt_o
    );

    // Front end / execute / issue side
    modport master (
        output v_i, data_i, deq_yumi_i, br_v_i, br_predicted_pc_i, br_actual_pc_i,
        input  ready_o, deq_v_o, deq_data_o, mis_predict_o, branch_mis_target_o,
               count_o, mispredict_cnt_o
    );
endinterface

// File: rtl/be_dispatch_queue.sv
// Back-end dispatch queue: buffers decoded instructions from the front end,
// hands them to issue with valid/yumi, and raises a one-cycle redirect pulse
// (squashing all buffered work) when execute resolves a mispredicted branch.
module be_dispatch_queue #(
    parameter int ELS_P      = 4,
    parameter int WIDTH_P    = 32,
    parameter int PC_WIDTH_P = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    be_dispatch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(ELS_P);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ELS_P);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                state_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  mis_predict_reg;
    logic [PC_WIDTH_P-1:0] target_reg;
    logic [15:0]           mispredict_cnt_reg;

    logic [WIDTH_P-1:0]    entries [ELS_P];

    logic running;
    logic mismatch;
    logic ready;
    logic deq_v;
    logic enq;
    logic deq;

    assign running  = (state_reg == S_RUN);
    assign mismatch = bus.br_v_i & (bus.br_predicted_pc_i != bus.br_actual_pc_i) & running;

    // ready only looks at occupancy and yumi, so a full queue can still take
    // an entry in the same cycle one leaves; v_i never feeds back into it.
    assign ready = running & ((count_reg < FULL_CNT) | bus.deq_yumi_i);

    // Everything buffered is younger than a resolving branch, so the head is
    // hidden from issue in the cycle a mismatch is detected.
    assign deq_v = running & ~mismatch & (count_reg != '0);

    assign enq = bus.v_i & ready & ~mismatch;
    assign deq = bus.deq_yumi_i & deq_v;

    // One storage slot per entry; written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < ELS_P; gi++) begin : g_entry
            logic [WIDTH_P-1:0] entry_reg;

            // Capture incoming instruction into this slot
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    entry_reg <= '0;
                end else if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= bus.data_i;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    // Recovery FSM plus pointer/occupancy bookkeeping and registered recovery outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg          <= S_RUN;
            rd_ptr_reg         <= '0;
            wr_ptr_reg         <= '0;
            count_reg          <= '0;
            mis_predict_reg    <= 1'b0;
            target_reg         <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (mismatch) begin
                        state_reg       <= S_FLUSH;
                        rd_ptr_reg      <= '0;
                        wr_ptr_reg      <= '0;
                        count_reg       <= '0;
                        mis_predict_reg <= 1'b1;
                        target_reg      <= bus.br_actual_pc_i;
                        if (mispredict_cnt_reg != 16'hFFFF) begin
                            mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
                        end
                    end else begin
                        mis_predict_reg <= 1'b0;
                        if (enq) begin
                            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                        end
                        if (deq) begin
                            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                        end
                        case ({enq, deq})
                            2'b10:   count_reg <= count_reg + CNT_W'(1);
                            2'b01:   count_reg <= count_reg - CNT_W'(1);
                            default: count_reg <= count_reg;
                        endcase
                    end
                end
                S_FLUSH: begin
                    // All inputs ignored here; execute squashes its own younger work.
                    state_reg       <= S_RUN;
                    mis_predict_reg <= 1'b0;
                end
                default: begin
                    state_reg       <= S_RUN;
                    mis_predict_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o             = ready;
    assign bus.deq_v_o             = deq_v;
    assign bus.deq_data_o          = entries[rd_ptr_reg];
    assign bus.mis_predict_o       = mis_predict_reg;
    assign bus.branch_mis_target_o = target_reg;
    assign bus.count_o             = count_reg;
    assign bus.mispredict_cnt_o    = mispredict_cnt_reg;
endmodule
